ctrl_load_sender: RTL and testbench

- Transmit side of the control-plane load protocol.
- Store-and-forward: collects one complete load image from an upstream valid/ready phit source into an internal buffer, then replays it to control_plane with no gaps.
- Replay is a start_loader pulse followed by state-table, config-table and inbound phits, one per cycle; this is required because control_plane cannot back-pressure loads.
- Then raises start_stream_in and holds it until control_plane acknowledges with ready_stream_in.

---
 rtl/ctrl_plane_pkg.sv | 50 +++++
 rtl/load_image_buf.sv | 39 +++
 rtl/ctrl_load_sender.sv | 194 +++++++++++++++++++
 tb/tb_ctrl_load_sender.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_plane_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_plane_pkg
//   Shared definitions for the control-plane load protocol.
//   - phit_size       : width of one phit on the load path
//   - dwidth_RFadd    : width of an entry-count field
//   - NUM_CFG_TABLES  : number of config tables in one load image
//   - cfg_table_e     : order in which config tables appear in the image
//   - sender_state_e  : states of the load sender FSM
//   - load_total()    : total phits in an image, computed without truncation
// ---------------------------------------------------------------------------
package ctrl_plane_pkg;

   localparam int phit_size      = 512;
   localparam int dwidth_RFadd   = 8;
   localparam int NUM_CFG_TABLES = 6;

   // state + 6*cfg + inbound never exceeds 8*max_count, so +4 bits is ample
   localparam int TOTAL_W = dwidth_RFadd + 4;

   typedef enum logic [2:0] {
      CFG_PEA0 = 3'd0,
      CFG_PEA1 = 3'd1,
      CFG_PEB  = 3'd2,
      CFG_PEC0 = 3'd3,
      CFG_PEC1 = 3'd4,
      CFG_PED  = 3'd5
   } cfg_table_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FILL   = 3'd1,
      LAUNCH = 3'd2,
      GAP    = 3'd3,
      SEND   = 3'd4,
      STREAM = 3'd5
   } sender_state_e;

   function automatic logic [TOTAL_W-1:0] load_total(
      input logic [dwidth_RFadd-1:0] n_state,
      input logic [dwidth_RFadd-1:0] n_cfg,
      input logic [dwidth_RFadd-1:0] n_inb
   );
      logic [TOTAL_W-1:0] t;
      t = TOTAL_W'(n_state)
        + TOTAL_W'(NUM_CFG_TABLES) * TOTAL_W'(n_cfg)
        + TOTAL_W'(n_inb);
      return t;
   endfunction

endpackage

// File: rtl/load_image_buf.sv
// ---------------------------------------------------------------------------
// load_image_buf
//   Simple dual-port RAM holding one load image. One write port, one read
//   port with a registered read (data appears the cycle after rd_en_i).
//   Ports:
//     clk        clock
//     wr_en_i    write strobe
//     wr_addr_i  write address
//     wr_data_i  write data
//     rd_en_i    read strobe
//     rd_addr_i  read address
//     rd_data_o  registered read data (holds while rd_en_i is low)
// ---------------------------------------------------------------------------
module load_image_buf #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 512,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // No reset: contents and read register are don't-care until written/read.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ctrl_load_sender.sv
// ---------------------------------------------------------------------------
// ctrl_load_sender
//   Transmit side of the control-plane load protocol. Collects a complete
//   load image from a valid/ready source into a local buffer, then replays
//   it gap-free behind a start_loader pulse (control_plane cannot stall a
//   load), then requests stream-in until acknowledged.
//   Ports:
//     clk, rst                  clock, async active-low reset
//     cmd_start                 one-cycle load request (IDLE only)
//     num_entry_state/_config_table/_inbound   entry counts (IDLE only)
//     s_data, s_valid, s_ready  upstream phit source
//     ready_stream_in           stream-in acknowledge from control_plane
//     wr_data                   phit to control_plane (0 when not sending)
//     start_loader              one-cycle load start pulse
//     start_stream_in           stream-in request
//     busy                      not IDLE
//     done                      one-cycle completion pulse
//     err_size                  sticky: last request had TOTAL 0 or > depth
// ---------------------------------------------------------------------------
module ctrl_load_sender
   import ctrl_plane_pkg::*;
#(
   parameter int BUF_DEPTH = 64,
   parameter int LOAD_GAP  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_start,
   input  logic [dwidth_RFadd-1:0] num_entry_state,
   input  logic [dwidth_RFadd-1:0] num_entry_config_table,
   input  logic [dwidth_RFadd-1:0] num_entry_inbound,
   input  logic [phit_size-1:0]    s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic                    ready_stream_in,
   output logic [phit_size-1:0]    wr_data,
   output logic                    start_loader,
   output logic                    start_stream_in,
   output logic                    busy,
   output logic                    done,
   output logic                    err_size
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam int GW = (LOAD_GAP > 1) ? $clog2(LOAD_GAP) : 1;

   sender_state_e      state_q, state_d;
   logic [TOTAL_W-1:0] total_q, total_d;
   logic [TOTAL_W-1:0] wcnt_q, wcnt_d;     // phits accepted
   logic [TOTAL_W-1:0] rcnt_q, rcnt_d;     // reads issued
   logic [AW-1:0]      wptr_q, wptr_d;
   logic [AW-1:0]      rptr_q, rptr_d;
   logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
   logic               err_q, err_d;
   logic               done_q, done_d;
   logic               send_vld_q, send_vld_d; // rd_data holds a live phit

   logic [TOTAL_W-1:0] total_new;
   logic               wr_en, rd_en, gap_last, accept;
   logic [phit_size-1:0] rd_data;

   assign total_new = load_total(num_entry_state, num_entry_config_table,
                                 num_entry_inbound);
   assign gap_last  = (gap_cnt_q == GW'(LOAD_GAP - 1));
   assign accept    = s_valid && s_ready;

   always_comb begin
      state_d    = state_q;
      total_d    = total_q;
      wcnt_d     = wcnt_q;
      rcnt_d     = rcnt_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      gap_cnt_d  = gap_cnt_q;
      err_d      = err_q;
      done_d     = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_start) begin
               if (total_new == '0 || total_new > TOTAL_W'(BUF_DEPTH)) begin
                  err_d = 1'b1;
               end else begin
                  err_d   = 1'b0;
                  total_d = total_new;
                  wcnt_d  = '0;
                  rcnt_d  = '0;
                  wptr_d  = '0;
                  rptr_d  = '0;
                  state_d = FILL;
               end
            end
         end
         FILL: begin
            if (accept) begin
               wr_en  = 1'b1;
               wptr_d = wptr_q + AW'(1);   // wraps to 0 on a full-depth image
               wcnt_d = wcnt_q + TOTAL_W'(1);
               if (wcnt_q + TOTAL_W'(1) == total_q) state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            gap_cnt_d = '0;
            // With no gap the first read must issue here to keep the
            // first phit exactly LOAD_GAP+1 cycles after start_loader.
            if (LOAD_GAP == 0) begin
               rd_en   = 1'b1;
               state_d = SEND;
            end else begin
               state_d = GAP;
            end
         end
         GAP: begin
            gap_cnt_d = gap_cnt_q + GW'(1);
            // Read one cycle early to cover the RAM read latency.
            if (gap_last) begin
               rd_en   = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            // The phit on wr_data this cycle was read last cycle; once all
            // reads are out, this is the last phit.
            if (rcnt_q != total_q) rd_en = 1'b1;
            else                   state_d = STREAM;
         end
         STREAM: begin
            if (ready_stream_in) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rd_en) begin
         rptr_d = rptr_q + AW'(1);
         rcnt_d = rcnt_q + TOTAL_W'(1);
      end
      send_vld_d = rd_en;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         total_q    <= '0;
         wcnt_q     <= '0;
         rcnt_q     <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         gap_cnt_q  <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         send_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         total_q    <= total_d;
         wcnt_q     <= wcnt_d;
         rcnt_q     <= rcnt_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         gap_cnt_q  <= gap_cnt_d;
         err_q      <= err_d;
         done_q     <= done_d;
         send_vld_q <= send_vld_d;
      end
   end

   load_image_buf #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (phit_size),
      .AW    (AW)
   ) u_buf (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wptr_q),
      .wr_data_i (s_data),
      .rd_en_i   (rd_en),
      .rd_addr_i (rptr_q),
      .rd_data_o (rd_data)
   );

   // Outputs decode from reset flops only, so reset forces them low at once.
   assign s_ready         = (state_q == FILL);
   assign start_loader    = (state_q == LAUNCH);
   assign start_stream_in = (state_q == STREAM);
   assign busy            = (state_q != IDLE);
   assign done            = done_q;
   assign err_size        = err_q;
   assign wr_data         = send_vld_q ? rd_data : '0;

endmodule

// File: tb/tb_ctrl_load_sender.sv
module tb_ctrl_load_sender;
   import ctrl_plane_pkg::*;

   localparam int DEPTH = 64;
   localparam int GAPC  = 2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    cmd_start;
   logic [dwidth_RFadd-1:0] num_entry_state, num_entry_config_table, num_entry_inbound;
   logic [phit_size-1:0]    s_data;
   logic                    s_valid, s_ready, ready_stream_in;
   logic [phit_size-1:0]    wr_data;
   logic                    start_loader, start_stream_in, busy, done, err_size;

   int nchk = 0;
   int nerr = 0;

   ctrl_load_sender #(.BUF_DEPTH(DEPTH), .LOAD_GAP(GAPC)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .cmd_start              (cmd_start),
      .num_entry_state        (num_entry_state),
      .num_entry_config_table (num_entry_config_table),
      .num_entry_inbound      (num_entry_inbound),
      .s_data                 (s_data),
      .s_valid                (s_valid),
      .s_ready                (s_ready),
      .ready_stream_in        (ready_stream_in),
      .wr_data                (wr_data),
      .start_loader           (start_loader),
      .start_stream_in        (start_stream_in),
      .busy                   (busy),
      .done                   (done),
      .err_size               (err_size)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [phit_size-1:0] act,
                      input logic [phit_size-1:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [phit_size-1:0] rnd_phit();
      logic [phit_size-1:0] p;
      for (int w = 0; w < phit_size / 32; w++) p[w*32 +: 32] = $urandom;
      return p;
   endfunction

   // One full load request. Reference model: the image is the queue of
   // accepted phits; replay must be exactly that queue starting GAPC+1
   // cycles after start_loader, then stream-in until ack, then done.
   task automatic run_load(input int st, input int cfg, input int inb,
                           input int vmode, input int dmode, input int ack_dly,
                           input bit cmd_in_send, input int exp_total,
                           input bit exp_err);
      logic [phit_size-1:0] q[$];
      int launch_t, sstart, ack_t, acc, dd, idx;
      bit finished;
      launch_t = -1; sstart = -1; ack_t = -1; acc = 0; finished = 1'b0;

      @(posedge clk); #1;
      cmd_start              = 1'b1;
      num_entry_state        = dwidth_RFadd'(st);
      num_entry_config_table = dwidth_RFadd'(cfg);
      num_entry_inbound      = dwidth_RFadd'(inb);
      s_valid                = 1'b0;
      ready_stream_in        = (ack_dly < 0);

      if (exp_err) begin
         for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            cmd_start = 1'b0;
            s_valid   = 1'b1;
            @(negedge clk);
            if (t == 0) chk("err_size_set", err_size, 1);
            chk("err_s_ready", s_ready, 0);
            chk("err_busy", busy, 0);
         end
         s_valid = 1'b0;
         ready_stream_in = 1'b0;
         return;
      end

      for (int t = 0; t < 1500; t++) begin
         @(posedge clk); #1;
         cmd_start = cmd_in_send && launch_t >= 0 && t == launch_t + GAPC + 3;
         // counts may change freely once the request has been taken
         num_entry_state        = dwidth_RFadd'($urandom);
         num_entry_config_table = dwidth_RFadd'($urandom);
         num_entry_inbound      = dwidth_RFadd'($urandom);
         case (vmode)
            0:       s_valid = 1'b1;
            1:       s_valid = (t % 3 == 0);
            default: s_valid = 1'($urandom_range(0, 1));
         endcase
         s_data = (dmode == 0) ? phit_size'(acc + 1) : rnd_phit();
         ready_stream_in = (ack_dly < 0) || (sstart >= 0 && t >= sstart + ack_dly);

         @(negedge clk);
         if (t == 0) begin
            chk("busy_after_cmd", busy, 1);
            chk("err_size_clear", err_size, 0);
         end
         if (acc >= exp_total && launch_t < 0) chk("s_ready_after_full", s_ready, 0);
         if (s_valid && s_ready) begin
            if (acc < exp_total) q.push_back(s_data);
            acc++;
         end
         if (start_loader) begin
            if (launch_t < 0) begin
               launch_t = t;
               sstart   = launch_t + GAPC + exp_total + 1;
               ack_t    = sstart + ((ack_dly < 0) ? 0 : ack_dly);
               chk("launch_after_fill", phit_size'(acc), phit_size'(exp_total));
            end else begin
               chk("start_loader_repeat", start_loader, 0);
            end
         end
         if (launch_t >= 0 && t > launch_t) begin
            dd = t - launch_t;
            if (dd <= GAPC) chk("gap_wr_data_zero", wr_data, 0);
            else if (dd <= GAPC + exp_total) begin
               idx = dd - GAPC - 1;
               if (idx < q.size()) chk($sformatf("phit%0d", idx), wr_data, q[idx]);
            end else if (dd == GAPC + exp_total + 1)
               chk("post_send_zero", wr_data, 0);
         end
         chk("start_stream_in", start_stream_in,
             phit_size'(launch_t >= 0 && t >= sstart && t <= ack_t));
         chk("done", done, phit_size'(launch_t >= 0 && t == ack_t + 1));
         if (launch_t >= 0 && t == ack_t + 1) begin
            chk("busy_after_done", busy, 0);
            finished = 1'b1;
            break;
         end
      end
      if (!finished) chk("load_timeout", 0, 1);
      cmd_start = 1'b0; s_valid = 1'b0; ready_stream_in = 1'b0;

      if (cmd_in_send) begin
         for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("ignored_cmd_busy", busy, 0);
            chk("ignored_cmd_s_ready", s_ready, 0);
         end
      end
   endtask

   typedef struct {
      int st, cfg, inb, vmode, dmode, ack;
      bit cis;
      int exp_total;
      bit exp_err;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int acc, launch_t, st, cfg, inb, tot;
      bit hit;
      vecs[0] = '{2, 2, 16, 0, 0,  5, 1'b0, 30, 1'b0};  // nominal FIR
      vecs[1] = '{2, 2, 16, 1, 1,  2, 1'b0, 30, 1'b0};  // bursty source
      vecs[2] = '{10, 4, 40, 0, 1, 0, 1'b0, 74, 1'b1};  // oversize
      vecs[3] = '{1, 1, 1, 2, 1,  0, 1'b0,  8, 1'b0};   // clears err_size
      vecs[4] = '{4, 0, 60, 0, 1, 1, 1'b0, 64, 1'b0};   // full depth
      vecs[5] = '{0, 0, 0, 0, 1,  0, 1'b0,  0, 1'b1};   // empty image
      vecs[6] = '{0, 0, 1, 0, 1, -1, 1'b0,  1, 1'b0};   // early ack held
      vecs[7] = '{3, 1, 5, 2, 1,  3, 1'b1, 14, 1'b0};   // cmd during SEND
      vecs[8] = '{0, 10, 4, 1, 1, 0, 1'b0, 64, 1'b0};   // full depth via cfg
      vecs[9] = '{0, 11, 0, 0, 1, 0, 1'b0, 66, 1'b1};   // just over depth

      rst = 1'b0; cmd_start = 1'b0; s_valid = 1'b0; ready_stream_in = 1'b0;
      s_data = '0; num_entry_state = '0; num_entry_config_table = '0;
      num_entry_inbound = '0;
      #12;
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_start_loader", start_loader, 0);
      chk("rst_err_size", err_size, 0);
      @(negedge clk); rst = 1'b1;

      foreach (vecs[i])
         run_load(vecs[i].st, vecs[i].cfg, vecs[i].inb, vecs[i].vmode,
                  vecs[i].dmode, vecs[i].ack, vecs[i].cis,
                  vecs[i].exp_total, vecs[i].exp_err);

      // Reset while phit 10 is on wr_data.
      @(posedge clk); #1;
      cmd_start = 1'b1; num_entry_state = 8'd2; num_entry_config_table = 8'd2;
      num_entry_inbound = 8'd16;
      acc = 0; launch_t = -1; hit = 1'b0;
      for (int t = 0; t < 300; t++) begin
         @(posedge clk); #1;
         cmd_start = 1'b0;
         s_valid   = 1'b1;
         s_data    = phit_size'(acc + 1);
         @(negedge clk);
         if (s_valid && s_ready) acc++;
         if (start_loader && launch_t < 0) launch_t = t;
         if (launch_t >= 0 && t == launch_t + GAPC + 10) begin hit = 1'b1; break; end
      end
      if (!hit) chk("rst_seq_timeout", 0, 1);
      chk("phit10_before_reset", wr_data, 10);
      #2 rst = 1'b0; s_valid = 1'b0;
      #1;
      chk("abort_wr_data", wr_data, 0);
      chk("abort_busy", busy, 0);
      chk("abort_s_ready", s_ready, 0);
      chk("abort_start_loader", start_loader, 0);
      chk("abort_start_stream_in", start_stream_in, 0);
      chk("abort_done", done, 0);
      @(negedge clk); rst = 1'b1;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         chk("no_done_after_abort", done, 0);
      end
      run_load(2, 2, 16, 0, 1, 1, 1'b0, 30, 1'b0);

      // Randomized requests against the arithmetic model.
      for (int r = 0; r < 8; r++) begin
         st  = $urandom_range(0, 20);
         cfg = $urandom_range(0, 8);
         inb = $urandom_range(0, 30);
         tot = st + NUM_CFG_TABLES * cfg + inb;
         run_load(st, cfg, inb, 2, 1, $urandom_range(0, 4), 1'b0, tot,
                  (tot == 0) || (tot > DEPTH));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
